rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Boot-time sequencer for the cpu core. Holds the cpu in reset and receives a program image as a UART byte stream.
//  Writes the image word-by-word into the instruction ROM write port, verifies a checksum, then releases the cpu.
//  Acks or naks over UART tx, and finally hands UART ownership to the cpu.
// PARAMETERS
//  ADDR_W       11        instruction ROM word-address width (matches cpu rom_addr)
//  SYNC_BYTE    8'hA5     frame start byte
//  ACK_BYTE     8'h06     reply on successful load
//  NAK_BYTE     8'h15     reply on any load failure
//  TIMEOUT_CYC  1_000_000 max clk cycles between rx bytes inside a frame
// PORTS
//  clk        in   1       clock
//  reset      in   1       reset, synchronous, active-high
//  rx_valid   in   1       one-cycle pulse: rx_data holds a received byte
//  rx_data    in   8       received byte
//  tx_req     out  1       one-cycle pulse: transmit tx_data
//  tx_data    out  8       byte to transmit, valid while tx_req=1
//  tx_busy    in   1       UART tx busy; tx_req only issued when 0
//  rom_we     out  1       one-cycle ROM write strobe
//  rom_waddr  out  ADDR_W  ROM word address
//  rom_wdata  out  32      ROM word data
//  cpu_reset  out  1       active-high reset to cpu core
//  cpu_owns_uart out 1     1 = top-level mux routes UART rx/tx to cpu
//  load_err   out  1       sticky: last frame failed (cleared by next SYNC_BYTE)
// BEHAVIOUR
//  Reset: state=IDLE. cpu_reset=1. tx_req, rom_we, cpu_owns_uart and load_err=0. rom_waddr, rom_wdata and tx_data=0. All counters 0.
//  Frame format: SYNC, LEN_LO, LEN_HI, then LEN words of 4 bytes each, little-endian, then CSUM.
//   LEN is 16-bit, little-endian. CSUM = 8-bit wrap-around sum of LEN_LO, LEN_HI and every payload byte.
//  States:
//   IDLE: rx byte==SYNC_BYTE -> LEN_LO, clear load_err and csum. Other bytes ignored.
//   LEN_LO / LEN_HI: capture LEN bytes, add to csum.
//    After LEN_HI: LEN > 2**ADDR_W -> NAK. LEN==0 -> CSUM. Otherwise -> DATA with word_idx=0 and byte_idx=0.
//   DATA: each byte is shifted into word[8*byte_idx +: 8] and added to csum.
//    On byte_idx==3, the next cycle drives rom_we=1, rom_waddr=word_idx, rom_wdata=assembled word.
//    word_idx then increments. Last word -> CSUM.
//   CSUM: rx byte==csum -> ACK. Otherwise -> NAK.
//   ACK: wait tx_busy==0, then pulse tx_req with tx_data=ACK_BYTE for 1 cycle -> RUN.
//   NAK: wait tx_busy==0, then pulse tx_req with tx_data=NAK_BYTE for 1 cycle, set load_err -> IDLE.
//   RUN: cpu_reset=0 and cpu_owns_uart=1 from the cycle after the ACK tx_req pulse. rx ignored.
//    RUN exits only via reset.
//  Timeout: counter clears on every rx_valid in LEN_LO, LEN_HI, DATA and CSUM, and increments otherwise.
//   When it reaches TIMEOUT_CYC-1 -> NAK. The counter is idle in other states.
//  rom_we: at most one pulse per 4 rx bytes. Never asserted outside DATA or the cycle after DATA.
//  rx_valid during ACK/NAK is dropped. rx_valid in the same cycle as a timeout expiry is dropped; NAK wins.
//  A failed frame leaves partial ROM contents. cpu_reset stays 1 until a full valid frame is loaded.
//  Reset mid-frame returns to IDLE on the next edge. Pending tx_req and rom_we are not issued.
//  Arithmetic: csum is 8-bit, mod 256. word_idx is ADDR_W+1 bits, so LEN = 2**ADDR_W is legal.
// TESTING
//  1. Load LEN=2: A5 02 00 | 13 00 00 00 | 6F 00 00 00 | csum=0x84
//     -> rom_we at addr 0 = 0x00000013 and addr 1 = 0x0000006F.
//     -> One tx_req with 0x06. cpu_reset falls 1 cycle later. cpu_owns_uart=1.
//  2. Same frame with csum=0x85 -> tx 0x15, load_err=1, cpu_reset stays 1.
//     Then resend the good frame -> load_err=0, ACK, run.
//  3. LEN=0x0801 (> 2048) -> NAK right after LEN_HI, no rom_we.
//     LEN=0x0800 with 8192 bytes -> last write at addr 0x7FF, then ACK.
//  4. Stop mid-word after 2 DATA bytes for TIMEOUT_CYC cycles (set to 100 in the bench)
//     -> NAK at cycle 100, state IDLE, no partial-word rom_we.
//  5. Hold tx_busy=1 for 50 cycles at ACK time -> tx_req issues the first cycle tx_busy=0, exactly once.
//  6. Garbage bytes 00 FF 12 in IDLE -> no response. Reset asserted in DATA
//     -> IDLE, cpu_reset=1, all pulse outputs 0. Bytes after RUN are ignored.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-time loader: receives a framed program image over UART, writes it into the
// instruction ROM, verifies the checksum, answers ACK/NAK and then releases the cpu.
module rom_loader #(
   parameter int         ADDR_W      = 11,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter logic [7:0] ACK_BYTE    = 8'h06,
   parameter logic [7:0] NAK_BYTE    = 8'h15,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_req,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_waddr,
   output logic [31:0]       rom_wdata,
   output logic              cpu_reset,
   output logic              cpu_owns_uart,
   output logic              load_err
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_ACK, S_NAK, S_RUN
   } state_t;

   state_t            state, state_next;
   logic [15:0]       len;
   logic [7:0]        csum;
   logic [31:0]       word;
   logic [1:0]        byte_idx;
   logic [ADDR_W:0]   word_idx;
   logic [TMO_W-1:0]  tmo;

   logic              in_frame;
   logic              expired;
   logic              take;
   logic [15:0]       len_full;
   logic [ADDR_W:0]   word_nxt;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_frame   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                   (state == S_DATA)   || (state == S_CSUM);
      expired    = in_frame && (tmo == TMO_W'(TIMEOUT_CYC - 1));
      // a byte arriving in the expiry cycle is dropped in favour of the NAK
      take       = rx_valid && !expired;
      len_full   = {rx_data, len[7:0]};
      word_nxt   = word_idx + 1'b1;
      case (state)
         S_IDLE:   if (rx_valid && rx_data == SYNC_BYTE) state_next = S_LEN_LO;
         S_LEN_LO: if (expired) state_next = S_NAK;
                   else if (take) state_next = S_LEN_HI;
         S_LEN_HI: if (expired) state_next = S_NAK;
                   else if (take) begin
                      if ({1'b0, len_full} > 17'(2**ADDR_W)) state_next = S_NAK;
                      else if (len_full == 16'd0)            state_next = S_CSUM;
                      else                                   state_next = S_DATA;
                   end
         S_DATA:   if (expired) state_next = S_NAK;
                   else if (take && byte_idx == 2'd3 && word_nxt == len[ADDR_W:0])
                      state_next = S_CSUM;
         S_CSUM:   if (expired) state_next = S_NAK;
                   else if (take) state_next = (rx_data == csum) ? S_ACK : S_NAK;
         S_ACK:    if (!tx_busy) state_next = S_RUN;
         S_NAK:    if (!tx_busy) state_next = S_IDLE;
         S_RUN:    state_next = S_RUN;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_req        <= 1'b0;
         tx_data       <= 8'd0;
         rom_we        <= 1'b0;
         rom_waddr     <= '0;
         rom_wdata     <= 32'd0;
         cpu_reset     <= 1'b1;
         cpu_owns_uart <= 1'b0;
         load_err      <= 1'b0;
         len           <= 16'd0;
         csum          <= 8'd0;
         word          <= 32'd0;
         byte_idx      <= 2'd0;
         word_idx      <= '0;
         tmo           <= '0;
      end else begin
         tx_req <= 1'b0;
         rom_we <= 1'b0;
         if (!in_frame || rx_valid || expired) tmo <= '0;
         else                                  tmo <= tmo + 1'b1;
         case (state)
            S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
               load_err <= 1'b0;
               csum     <= 8'd0;
            end
            S_LEN_LO: if (take) begin
               len[7:0] <= rx_data;
               csum     <= csum + rx_data;
            end
            S_LEN_HI: if (take) begin
               len[15:8] <= rx_data;
               csum      <= csum + rx_data;
               word_idx  <= '0;
               byte_idx  <= 2'd0;
            end
            S_DATA: if (take) begin
               word[{byte_idx, 3'b000} +: 8] <= rx_data;
               csum     <= csum + rx_data;
               byte_idx <= byte_idx + 1'b1;
               if (byte_idx == 2'd3) begin
                  rom_we    <= 1'b1;
                  rom_waddr <= word_idx[ADDR_W-1:0];
                  rom_wdata <= {rx_data, word[23:0]};
                  word_idx  <= word_nxt;
               end
            end
            S_ACK: if (!tx_busy) begin
               tx_req  <= 1'b1;
               tx_data <= ACK_BYTE;
            end
            S_NAK: if (!tx_busy) begin
               tx_req   <= 1'b1;
               tx_data  <= NAK_BYTE;
               load_err <= 1'b1;
            end
            S_RUN: begin
               cpu_reset     <= 1'b0;
               cpu_owns_uart <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven random frames against a byte-level
// frame model, plus directed sequences for timeout, tx back-pressure and reset corners.
module tb_rom_loader;

   localparam int ADDR_W = 11;
   localparam int TMO    = 100;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'd0;
   logic              tx_req;
   logic [7:0]        tx_data;
   logic              tx_busy = 1'b0;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_waddr;
   logic [31:0]       rom_wdata;
   logic              cpu_reset;
   logic              cpu_owns_uart;
   logic              load_err;

   rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
      .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
      .cpu_reset(cpu_reset), .cpu_owns_uart(cpu_owns_uart), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] rom_obs [0:2047];
   int          wr_cnt = 0;
   int          last_waddr = -1;
   logic [7:0]  tx_q [$];
   int          tx_cyc = -1;
   int          fall_cyc = -1;
   int          last_rx_cyc = 0;
   logic        prev_cr = 1'b1;
   logic        last_busy = 1'b0;
   logic [31:0] pay [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // observe DUT outputs on the falling edge
   always @(negedge clk) begin
      if (rom_we) begin
         rom_obs[rom_waddr] = rom_wdata;
         wr_cnt++;
         last_waddr = int'(rom_waddr);
      end
      if (tx_req) begin
         tx_q.push_back(tx_data);
         tx_cyc = cyc;
         chk("tx_req while busy", {63'd0, last_busy}, 64'd0);
      end
      if (prev_cr && !cpu_reset) fall_cyc = cyc;
      prev_cr   = cpu_reset;
      last_busy = tx_busy;
   end

   task automatic clear_obs();
      for (int i = 0; i < 2048; i++) rom_obs[i] = 'x;
      wr_cnt = 0; last_waddr = -1; tx_q.delete(); tx_cyc = -1; fall_cyc = -1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; rx_valid = 1'b0; tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      clear_obs();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = b;
      @(posedge clk); #1;
      last_rx_cyc = cyc;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   // frame model: checksum is the byte sum of LEN and payload, mod 256
   task automatic send_frame(input int len, input bit corrupt, input int gap);
      int s;
      s = (len & 255) + ((len >> 8) & 255);
      send_byte(8'hA5, gap);
      send_byte(8'(len), gap);
      send_byte(8'(len >> 8), gap);
      for (int w = 0; w < len; w++)
         for (int k = 0; k < 4; k++) begin
            s += (pay[w] >> (8 * k)) & 255;
            send_byte(8'(pay[w] >> (8 * k)), gap);
         end
      send_byte(8'(s + (corrupt ? 1 : 0)), gap);
   endtask

   task automatic rand_payload(input int n);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back($urandom);
   endtask

   task automatic expect_tx(input string nm, input logic [7:0] exp, input int budget);
      for (int i = 0; i < budget && tx_q.size() == 0; i++) @(posedge clk);
      if (tx_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: no tx within %0d cycles, expected %0h", nm, budget, exp);
      end else chk(nm, {56'd0, tx_q.pop_front()}, {56'd0, exp});
   endtask

   task automatic check_rom(input string nm, input int n);
      int miss = 0;
      for (int i = 0; i < n; i++) if (rom_obs[i] !== pay[i]) miss++;
      chk(nm, 64'(miss), 64'd0);
      chk({nm, " count"}, 64'(wr_cnt), 64'(n));
   endtask

   typedef struct {
      int len; bit corrupt; int gap; bit exp_ack;
   } vec_t;
   vec_t vecs [7];

   initial begin
      logic [7:0] pre;
      int rel;

      vecs[0] = '{len: 1, corrupt: 0, gap: 0, exp_ack: 1};
      vecs[1] = '{len: 3, corrupt: 1, gap: 2, exp_ack: 0};
      vecs[2] = '{len: 5, corrupt: 0, gap: 1, exp_ack: 1};
      vecs[3] = '{len: 0, corrupt: 0, gap: 0, exp_ack: 1};
      vecs[4] = '{len: 0, corrupt: 1, gap: 3, exp_ack: 0};
      vecs[5] = '{len: 7, corrupt: 1, gap: 0, exp_ack: 0};
      vecs[6] = '{len: 16, corrupt: 0, gap: 5, exp_ack: 1};

      do_reset();
      @(negedge clk);
      chk("rst cpu_reset", {63'd0, cpu_reset}, 64'd1);
      chk("rst tx_req", {63'd0, tx_req}, 64'd0);
      chk("rst rom_we", {63'd0, rom_we}, 64'd0);
      chk("rst owns", {63'd0, cpu_owns_uart}, 64'd0);
      chk("rst load_err", {63'd0, load_err}, 64'd0);
      chk("rst outs", {rom_wdata, 13'd0, rom_waddr, tx_data}, 64'd0);

      // known-good two-word load, then traffic after RUN is ignored
      pay.delete(); pay.push_back(32'h13); pay.push_back(32'h6F);
      send_frame(2, 0, 0);
      expect_tx("t1 ack", 8'h06, 20);
      check_rom("t1 rom", 2);
      repeat (3) @(posedge clk);
      chk("t1 fall", 64'(fall_cyc), 64'(tx_cyc + 1));
      chk("t1 owns", {63'd0, cpu_owns_uart}, 64'd1);
      send_frame(2, 0, 0);
      repeat (20) @(posedge clk);
      chk("run ignores rx tx", 64'(tx_q.size()), 64'd0);
      chk("run ignores rx we", 64'(wr_cnt), 64'd2);
      chk("run cpu_reset", {63'd0, cpu_reset}, 64'd0);

      // bad checksum then retry
      do_reset();
      send_frame(2, 1, 0);
      expect_tx("t2 nak", 8'h15, 20);
      @(negedge clk);
      chk("t2 load_err", {63'd0, load_err}, 64'd1);
      chk("t2 cpu_reset", {63'd0, cpu_reset}, 64'd1);
      send_frame(2, 0, 0);
      expect_tx("t2 retry ack", 8'h06, 20);
      @(negedge clk);
      chk("t2 err cleared", {63'd0, load_err}, 64'd0);

      // table-driven random frames
      foreach (vecs[v]) begin
         do_reset();
         rand_payload(vecs[v].len);
         send_frame(vecs[v].len, vecs[v].corrupt, vecs[v].gap);
         expect_tx($sformatf("vec%0d reply", v), vecs[v].exp_ack ? 8'h06 : 8'h15, 30);
         check_rom($sformatf("vec%0d rom", v), vecs[v].len);
         repeat (3) @(negedge clk);
         chk($sformatf("vec%0d cpu_reset", v), {63'd0, cpu_reset}, {63'd0, !vecs[v].exp_ack});
         chk($sformatf("vec%0d load_err", v), {63'd0, load_err}, {63'd0, !vecs[v].exp_ack});
      end

      // oversize length is rejected right after LEN_HI
      do_reset();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h08, 0);
      expect_tx("len 0x801 nak", 8'h15, 6);
      chk("len 0x801 no we", 64'(wr_cnt), 64'd0);

      // maximum legal length fills the whole ROM
      do_reset();
      rand_payload(2048);
      send_frame(2048, 0, 0);
      expect_tx("len 0x800 ack", 8'h06, 20);
      check_rom("len 0x800 rom", 2048);
      chk("len 0x800 last addr", 64'(last_waddr), 64'h7FF);

      // timeout mid-word
      do_reset();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      expect_tx("tmo nak", 8'h15, TMO + 20);
      chk("tmo not early", 64'(tx_cyc - last_rx_cyc >= TMO), 64'd1);
      chk("tmo not late", 64'(tx_cyc - last_rx_cyc <= TMO + 2), 64'd1);
      chk("tmo no we", 64'(wr_cnt), 64'd0);
      pay.delete(); pay.push_back(32'hCAFE0001);
      send_frame(1, 0, 0);
      expect_tx("tmo then ack", 8'h06, 20);

      // tx back-pressure at ACK time
      do_reset();
      rand_payload(2);
      tx_busy = 1'b1;
      send_frame(2, 0, 0);
      repeat (50) @(posedge clk);
      chk("busy holds tx", 64'(tx_q.size()), 64'd0);
      #1 tx_busy = 1'b0;
      rel = cyc;
      expect_tx("busy ack", 8'h06, 10);
      chk("busy ack timing", 64'(tx_cyc), 64'(rel + 1));
      repeat (20) @(posedge clk);
      chk("busy ack once", 64'(tx_q.size()), 64'd0);

      // garbage in IDLE, then reset landing on a word-completing byte
      do_reset();
      send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h12, 0);
      repeat (20) @(posedge clk);
      chk("garbage no tx", 64'(tx_q.size()), 64'd0);
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = 8'hDD; reset = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("mid rst we", {63'd0, rom_we}, 64'd0);
      chk("mid rst tx", {63'd0, tx_req}, 64'd0);
      chk("mid rst cpu_reset", {63'd0, cpu_reset}, 64'd1);
      repeat (5) @(posedge clk);
      chk("mid rst no write", 64'(wr_cnt), 64'd0);
      pre = 8'h00;
      pay.delete(); pay.push_back(32'h00C0FFEE);
      send_frame(1, 0, 0);
      expect_tx("after rst ack", 8'h06, 20);
      chk("after rst rom", {32'd0, rom_obs[0]}, {32'd0, pay[0]});
      chk("pre unused", {56'd0, pre}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
